beep_sequencer: RTL and testbench

- Drives the 9-bit `freq` input of the tone generator from queued-free, one-at-a-time beep commands.
- Each beep has a duration and an optional pitch sweep that bounces between two pitch values.
- Sits between the CPU/IPC sound register interface and the tone generator.
- `freq` = 0 means silence.

---
 rtl/sound_pkg.sv | 24 ++
 rtl/beep_sequencer_tick_divider.sv | 39 +++
 rtl/beep_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_beep_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the beep sequencer: FSM state encoding, field
// widths and the packed beep command payload.
package sound_pkg;

  localparam int unsigned FREQ_W       = 9;
  localparam int unsigned DUR_W        = 16;
  localparam int unsigned STEP_W       = 4;
  localparam int unsigned STEP_TICKS_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } beep_state_e;

  // One beep command as latched at the handshake.
  typedef struct packed {
    logic [FREQ_W-1:0]       pitch_a;
    logic [FREQ_W-1:0]       pitch_b;
    logic [STEP_W-1:0]       step;
    logic [STEP_TICKS_W-1:0] step_ticks;
    logic [DUR_W-1:0]        duration;
  } beep_cmd_t;

endpackage

// File: rtl/beep_sequencer_tick_divider.sv
// tick_divider: prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ
// cycles while enabled.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset
//   clear  - restart the count at 0 (next tick is a full period away)
//   enable - count only when high; count holds 0 otherwise
//   tick   - high during the terminal-count cycle while enabled
module tick_divider #(
  parameter int unsigned CLK_HZ  = 27000000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned DIV   = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running modulo-DIV counter, parked at 0 when idle or cleared.
  always_ff @(posedge clk) begin
    if (reset || clear || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer: plays one beep command at a time into the tone generator's
// freq input, with a fixed duration and an optional pitch sweep bouncing
// between pitch_a and pitch_b. freq = 0 is silence.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake (cmd_ready depends on state only)
//   cmd_pitch_a/_b        - sweep start / end pitch
//   cmd_step              - pitch increment per sweep step (0 = constant)
//   cmd_step_ticks        - ticks between sweep steps (0 = constant)
//   cmd_duration          - beep length in ticks (0 = until stop)
//   stop                  - abort the current beep
//   freq, busy, done      - tone code, playing flag, end-of-beep pulse
// Optional: define BEEP_PREEMPT_EN to let a new command restart a playing beep.
module beep_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 27000000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [FREQ_W-1:0]       cmd_pitch_a,
  input  logic [FREQ_W-1:0]       cmd_pitch_b,
  input  logic [STEP_W-1:0]       cmd_step,
  input  logic [STEP_TICKS_W-1:0] cmd_step_ticks,
  input  logic [DUR_W-1:0]        cmd_duration,
  input  logic                    stop,
  output logic [FREQ_W-1:0]       freq,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned PW = FREQ_W + 1;

  beep_state_e             state, state_d;
  beep_cmd_t               cmd_q, cmd_d;
  logic [FREQ_W-1:0]       freq_d;
  logic                    busy_d, done_d;
  logic                    dir_up, dir_up_d;
  logic                    sweep_en, sweep_en_d;
  logic [DUR_W-1:0]        elapsed, elapsed_d;
  logic [STEP_TICKS_W-1:0] step_cnt, step_cnt_d;

  logic                    accept_c;
  logic                    clear_c;
  logic                    tick;
  beep_cmd_t               new_cmd_c;

  logic [PW-1:0]           cur_w, hi_w, lo_w, up_w, dn_w;
  logic [DUR_W:0]          elapsed_inc;
  logic [STEP_TICKS_W:0]   step_inc;
  logic                    expire_c, step_hit_c;

`ifdef BEEP_PREEMPT_EN
  assign cmd_ready = 1'b1;
`else
  assign cmd_ready = (state == IDLE);
`endif

  assign accept_c = cmd_valid && cmd_ready;

  assign new_cmd_c = '{pitch_a:    cmd_pitch_a,
                       pitch_b:    cmd_pitch_b,
                       step:       cmd_step,
                       step_ticks: cmd_step_ticks,
                       duration:   cmd_duration};

  // Restart the prescaler on accept and keep it parked outside PLAY.
  assign clear_c = accept_c || (state_d != PLAY);

  tick_divider #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_c),
    .enable (state == PLAY),
    .tick   (tick)
  );

  // Sweep and duration arithmetic, one bit wider so nothing wraps.
  always_comb begin
    cur_w       = {1'b0, freq};
    hi_w        = (cmd_q.pitch_a > cmd_q.pitch_b) ? {1'b0, cmd_q.pitch_a} : {1'b0, cmd_q.pitch_b};
    lo_w        = (cmd_q.pitch_a > cmd_q.pitch_b) ? {1'b0, cmd_q.pitch_b} : {1'b0, cmd_q.pitch_a};
    up_w        = cur_w + PW'(cmd_q.step);
    dn_w        = cur_w - PW'(cmd_q.step);
    elapsed_inc = {1'b0, elapsed} + (DUR_W+1)'(1);
    step_inc    = {1'b0, step_cnt} + (STEP_TICKS_W+1)'(1);
    expire_c    = (cmd_q.duration != '0) && (elapsed_inc == {1'b0, cmd_q.duration});
    step_hit_c  = (step_inc == {1'b0, cmd_q.step_ticks});
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cmd_q    <= '0;
      freq     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dir_up   <= 1'b0;
      sweep_en <= 1'b0;
      elapsed  <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_d;
      cmd_q    <= cmd_d;
      freq     <= freq_d;
      busy     <= busy_d;
      done     <= done_d;
      dir_up   <= dir_up_d;
      sweep_en <= sweep_en_d;
      elapsed  <= elapsed_d;
      step_cnt <= step_cnt_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state;
    cmd_d      = cmd_q;
    freq_d     = freq;
    busy_d     = busy;
    done_d     = 1'b0;
    dir_up_d   = dir_up;
    sweep_en_d = sweep_en;
    elapsed_d  = elapsed;
    step_cnt_d = step_cnt;

    case (state)
      IDLE: begin
        if (accept_c) begin
          state_d    = PLAY;
          cmd_d      = new_cmd_c;
          freq_d     = cmd_pitch_a;
          busy_d     = 1'b1;
          dir_up_d   = (cmd_pitch_b > cmd_pitch_a);
          sweep_en_d = (cmd_pitch_a != cmd_pitch_b) && (cmd_step != '0) && (cmd_step_ticks != '0);
          elapsed_d  = '0;
          step_cnt_d = '0;
        end
      end

      PLAY: begin
        if (stop) begin
          // Stop beats a same-cycle command and any tick event.
          state_d    = IDLE;
          freq_d     = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          elapsed_d  = '0;
          step_cnt_d = '0;
        end else if (accept_c) begin
          // Only reachable with preemption: restart silently with new fields.
          cmd_d      = new_cmd_c;
          freq_d     = cmd_pitch_a;
          dir_up_d   = (cmd_pitch_b > cmd_pitch_a);
          sweep_en_d = (cmd_pitch_a != cmd_pitch_b) && (cmd_step != '0) && (cmd_step_ticks != '0);
          elapsed_d  = '0;
          step_cnt_d = '0;
        end else if (tick) begin
          elapsed_d = elapsed_inc[DUR_W-1:0];
          if (expire_c) begin
            // Expiry wins over a sweep step landing on the same tick.
            state_d    = IDLE;
            freq_d     = '0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            elapsed_d  = '0;
            step_cnt_d = '0;
          end else if (sweep_en) begin
            if (step_hit_c) begin
              step_cnt_d = '0;
              if (dir_up) begin
                if (up_w >= hi_w) begin
                  freq_d   = hi_w[FREQ_W-1:0];
                  dir_up_d = 1'b0;
                end else begin
                  freq_d = up_w[FREQ_W-1:0];
                end
              end else begin
                if ($signed(dn_w) <= $signed(lo_w)) begin
                  freq_d   = lo_w[FREQ_W-1:0];
                  dir_up_d = 1'b1;
                end else begin
                  freq_d = dn_w[FREQ_W-1:0];
                end
              end
            end else begin
              step_cnt_d = step_inc[STEP_TICKS_W-1:0];
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer at 10 clock cycles per tick.
module tb_beep_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_pitch_a;
  logic [8:0] cmd_pitch_b;
  logic [3:0] cmd_step;
  logic [7:0] cmd_step_ticks;
  logic [15:0] cmd_duration;
  logic       stop;
  logic [8:0] freq;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  beep_sequencer #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_pitch_a    (cmd_pitch_a),
    .cmd_pitch_b    (cmd_pitch_b),
    .cmd_step       (cmd_step),
    .cmd_step_ticks (cmd_step_ticks),
    .cmd_duration   (cmd_duration),
    .stop           (stop),
    .freq           (freq),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Offer one command at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [8:0] a, input logic [8:0] b, input logic [3:0] st,
                      input logic [7:0] stt, input logic [15:0] dur);
    cmd_pitch_a = a; cmd_pitch_b = b; cmd_step = st;
    cmd_step_ticks = stt; cmd_duration = dur; cmd_valid = 1'b1;
    check("send_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for done; at = cycle index of first pulse (-1 if none).
  task automatic watch_done(input int max, output int at, output int pulses);
    at = -1; pulses = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
  endtask

  // Pop one expected pitch per tick and compare.
  task automatic drain_ticks(input string tag);
    logic [8:0] e;
    while (exp_q.size() > 0) begin
      repeat (10) @(negedge clk);
      e = exp_q.pop_front();
      check(tag, freq, e);
      if (exp_q.size() == 0) check({tag, "_done"}, done, 1);
    end
  endtask

  initial begin
    int at, pulses, bad;
    reset = 1'b1; cmd_valid = 1'b0; stop = 1'b0;
    cmd_pitch_a = '0; cmd_pitch_b = '0; cmd_step = '0; cmd_step_ticks = '0; cmd_duration = '0;
    repeat (3) @(negedge clk);
    check("rst_freq", freq, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // Constant pitch, 5 ticks.
    send(9'd100, 9'd100, 4'd0, 8'd1, 16'd5);
    check("t1_freq", freq, 100);
    check("t1_busy", busy, 1);
    watch_done(60, at, pulses);
    check("t1_done_at", at, 50);
    check("t1_pulses", pulses, 1);
    check("t1_freq_end", freq, 0);
    check("t1_busy_end", busy, 0);

    // Up sweep that bounces off both ends.
    send(9'd100, 9'd110, 4'd4, 8'd1, 16'd8);
    check("t2_first", freq, 100);
    exp_q.push_back(104); exp_q.push_back(108); exp_q.push_back(110);
    exp_q.push_back(106); exp_q.push_back(102); exp_q.push_back(100);
    exp_q.push_back(104); exp_q.push_back(0);
    drain_ticks("t2_sweep");
    @(negedge clk);

    // Down sweep clamps at 0 without wrapping.
    send(9'd5, 9'd0, 4'd4, 8'd1, 16'd4);
    check("t3_first", freq, 5);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(0);
    drain_ticks("t3_sweep");
    @(negedge clk);

    // Endless beep, stop, then stop while idle.
    send(9'd200, 9'd200, 4'd0, 8'd0, 16'd0);
    bad = 0; pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (freq !== 9'd200) bad++;
      if (done !== 1'b0) pulses++;
    end
    check("t4_hold_bad", bad, 0);
    check("t4_no_done", pulses, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_stop_freq", freq, 0);
    check("t4_stop_done", done, 1);
    check("t4_stop_busy", busy, 0);
    @(negedge clk);
    check("t4_done_1cyc", done, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_idle_stop", done, 0);
    @(negedge clk);

    // Handshake while playing.
`ifdef BEEP_PREEMPT_EN
    send(9'd200, 9'd200, 4'd0, 8'd0, 16'd0);
    cmd_pitch_a = 9'd300; cmd_pitch_b = 9'd300; cmd_duration = 16'd0; cmd_valid = 1'b1;
    check("t5_ready_play", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t5_preempt_freq", freq, 300);
    check("t5_preempt_nodone", done, 0);
    check("t5_preempt_busy", busy, 1);
    stop = 1'b1; cmd_valid = 1'b1; cmd_pitch_a = 9'd400; cmd_pitch_b = 9'd400;
    @(negedge clk);
    stop = 1'b0; cmd_valid = 1'b0;
    check("t5_stopacc_freq", freq, 0);
    check("t5_stopacc_done", done, 1);
    check("t5_stopacc_busy", busy, 0);
`else
    send(9'd200, 9'd200, 4'd0, 8'd0, 16'd3);
    cmd_pitch_a = 9'd300; cmd_pitch_b = 9'd300; cmd_duration = 16'd0; cmd_valid = 1'b1;
    bad = 0; at = -1;
    check("t5_ready_play", cmd_ready, 0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = i;
        break;
      end
      if (cmd_ready !== 1'b0 || freq !== 9'd200) bad++;
    end
    check("t5_done_at", at, 30);
    check("t5_blocked_bad", bad, 0);
    check("t5_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t5_late_accept", freq, 300);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t5_stop_done", done, 1);
    check("t5_stop_freq", freq, 0);
`endif
    @(negedge clk);

    // Reset mid-sweep, then a fresh beep gets a full first tick.
    send(9'd100, 9'd110, 4'd4, 8'd1, 16'd0);
    repeat (25) @(negedge clk);
    check("t6_pre_rst", freq, 108);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_rst_freq", freq, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", cmd_ready, 1);
    check("t6_rst_done", done, 0);
    send(9'd50, 9'd50, 4'd0, 8'd0, 16'd1);
    check("t6_fresh_freq", freq, 50);
    watch_done(20, at, pulses);
    check("t6_full_tick", at, 10);
    check("t6_pulses", pulses, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
